spi_master_ctrl: RTL
====================

Name: spi_master_ctrl

Overview:
- Transaction controller that sequences one SPI frame of 1..2^LEN_W-1 bytes from a byte-wide TX handshake.
- Generates SCLK (mode 0: CPOL=0, CPHA=0), drives CS_N, and shifts MOSI/MISO through internal 8-bit TX/RX shift registers.
- Sits between the host-side byte source/sink and the serial pins; replaces free-running CLK gating with a divided, state-controlled SCLK.

Parameters:
CLK_DIV, 4, CLK cycles per SCLK half-period; legal range 1..255.
LEN_W, 4, width of the LEN byte-count input.

Ports:
CLK  input  1  system clock; all state changes on rising edge.
CLR  input  1  reset; asynchronous, active-high.
START  input  1  request a frame; sampled only in IDLE.
LEN  input  LEN_W  bytes in the frame; latched on accepted START.
TX_DATA  input  8  next byte to transmit.
TX_VALID  input  1  TX_DATA valid.
TX_READY  output  1  controller accepts TX_DATA this cycle.
RX_DATA  output  8  last received byte.
RX_VALID  output  1  one-cycle pulse; RX_DATA updated.
MISO  input  1  serial data in.
MOSI  output  1  serial data out.
SCLK  output  1  serial clock.
CS_N  output  1  chip select, active-low.
BUSY  output  1  high in every state except IDLE.
DONE  output  1  one-cycle pulse at frame end.

Behaviour:
- Reset values (CLR=1, asynchronous):
  - State IDLE; all counters and shift registers 0.
  - CS_N=1, SCLK=0, MOSI=0, TX_READY=0, RX_VALID=0, DONE=0, BUSY=0, RX_DATA=8'h00.
- FSM states: IDLE, LOAD, SHIFT, HOLD.
- IDLE:
  - START=1 and LEN!=0: latch LEN into bytes_left and go to LOAD.
  - START=1 with LEN=0 is ignored (no BUSY, no DONE).
- LOAD:
  - CS_N=0, SCLK=0, TX_READY=1.
  - On TX_VALID&TX_READY: load TX shift register, clear bit and divider counters, go to SHIFT.
  - No TX_VALID: stay in LOAD with CS_N low and SCLK low (underrun stall, unbounded).
- SHIFT:
  - Divider counts 0..CLK_DIV-1; at terminal count SCLK toggles.
  - On the 0->1 toggle: sample MISO into the RX shift register.
  - On the 1->0 toggle: shift the TX register and increment the bit count.
  - MOSI equals the current TX output bit throughout SHIFT.
  - After the 8th falling toggle (16*CLK_DIV cycles in SHIFT):
    - RX_DATA <= assembled byte; RX_VALID=1 for exactly one cycle; bytes_left decrements.
    - bytes_left reaches 0: go to HOLD. Otherwise go to LOAD.
- HOLD:
  - CS_N stays low for CLK_DIV cycles, then goes to IDLE.
  - On the transition: CS_N=1 and DONE=1 for one cycle.
- Latency: with TX_VALID already high, DONE pulses 2+17*CLK_DIV cycles after the START-sampling edge. Each extra byte adds 1+16*CLK_DIV cycles.
- Bit order: LSB first by default. TX shifts right, MISO enters at bit 7.
- START while BUSY is ignored. TX_VALID outside LOAD is ignored (TX_READY=0).
- No RX backpressure. RX_DATA holds its value until the next byte completes.
- CLR mid-frame: CS_N=1 and SCLK=0 immediately (asynchronously). RX_DATA returns to 0. No RX_VALID or DONE is emitted.
- MOSI is 0 whenever not in SHIFT.

Optional Feature:
- Macro SPI_MSB_FIRST_EN.
- Defined:
  - TX shifts left and MOSI=tx_shift[7].
  - MISO enters at bit 0.
  - The byte is transmitted and received MSB first.
- Undefined: LSB first as described above.
- Timing and handshakes are identical in both builds.

Test Plan:
1. CLK_DIV=4, LEN=1, TX_DATA=8'hA5 held valid, MISO tied to MOSI -> MOSI bit sequence 1,0,1,0,0,1,0,1; RX_VALID once with RX_DATA=8'hA5; DONE 70 cycles after START; CS_N low until DONE.
2. LEN=3, TX bytes 8'h01, 8'h80, 8'hFF, MISO tied to 1 -> three RX_VALID pulses, each RX_DATA=8'hFF; exactly three TX_READY&TX_VALID handshakes; CS_N never deasserts between bytes; one DONE.
3. LEN=2, TX_VALID dropped for 20 cycles before byte 2 -> controller stays in LOAD, SCLK stays 0 and CS_N stays 0 for the full 20 cycles; the transfer then resumes and completes normally.
4. CLR pulsed at bit 4 of byte 1 -> CS_N=1, SCLK=0, BUSY=0, RX_DATA=8'h00 with no CLK edge; no DONE; the next START with LEN=1 completes cleanly.
5. START re-asserted during SHIFT, and START with LEN=0 in IDLE -> both ignored; BUSY is unchanged by each; exactly one DONE for the original frame.
6. Build with SPI_MSB_FIRST_EN, TX_DATA=8'hA5, loopback -> MOSI bit sequence 1,0,1,0,0,1,0,1 transmitted MSB first; RX_DATA=8'hA5. TX_DATA=8'h01 -> seven 0 bits then a 1.

Source files
------------

// File: rtl/spi_master_ctrl_if.sv
// spi_master_ctrl_if: host byte handshake and SPI pin bundle for spi_master_ctrl
interface spi_master_ctrl_if #(
    parameter int LEN_W = 4
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             miso;
    logic             mosi;
    logic             sclk;
    logic             cs_n;
    logic             busy;
    logic             done;

    modport master (
        input  start, len, tx_data, tx_valid, miso,
        output tx_ready, rx_data, rx_valid, mosi, sclk, cs_n, busy, done
    );

    modport slave (
        output start, len, tx_data, tx_valid, miso,
        input  tx_ready, rx_data, rx_valid, mosi, sclk, cs_n, busy, done
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: mode-0 SPI frame sequencer, 1..2^LEN_W-1 bytes per frame.
// Build option SPI_MSB_FIRST_EN: shift bytes MSB first (default LSB first).
module spi_master_ctrl #(
    parameter int CLK_DIV = 4,
    parameter int LEN_W   = 4
) (
    input logic               clk,
    input logic               clr,
    spi_master_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, HOLD} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t           state, state_nx;
    logic [7:0]       div_cnt;
    logic [2:0]       bit_cnt;
    logic [LEN_W-1:0] bytes_left;
    logic [7:0]       tx_shift, rx_shift, rx_data;
    logic             sclk, rx_valid, done;
    logic             tick, rise, fall, last, tx_bit;
    logic [7:0]       tx_next, rx_next;

`ifdef SPI_MSB_FIRST_EN
    assign tx_bit  = tx_shift[7];
    assign tx_next = {tx_shift[6:0], 1'b0};
    assign rx_next = {rx_shift[6:0], bus.miso};
`else
    assign tx_bit  = tx_shift[0];
    assign tx_next = {1'b0, tx_shift[7:1]};
    assign rx_next = {bus.miso, rx_shift[7:1]};
`endif

    assign tick = div_cnt == DIV_LAST;
    assign rise = tick && !sclk;
    assign fall = tick && sclk;
    assign last = fall && bit_cnt == 3'd7;

    assign bus.cs_n     = state == IDLE;
    assign bus.busy     = state != IDLE;
    assign bus.tx_ready = state == LOAD;
    assign bus.mosi     = (state == SHIFT) && tx_bit;
    assign bus.sclk     = sclk;
    assign bus.rx_data  = rx_data;
    assign bus.rx_valid = rx_valid;
    assign bus.done     = done;

    // state register; reset drops CS_N and stops SCLK without waiting for a clock
    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= IDLE;
        else     state <= state_nx;
    end

    // next state: LOAD stalls on missing TX byte, last byte of the frame goes to HOLD
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (bus.start && bus.len != '0) ? LOAD : IDLE;
            LOAD:    state_nx = bus.tx_valid ? SHIFT : LOAD;
            SHIFT:   state_nx = !last ? SHIFT : (bytes_left == LEN_W'(1)) ? HOLD : LOAD;
            default: state_nx = tick ? IDLE : HOLD;
        endcase
    end

    // divider, shift registers, byte counter and the one-cycle status pulses
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            div_cnt    <= '0;
            bit_cnt    <= '0;
            bytes_left <= '0;
            tx_shift   <= '0;
            rx_shift   <= '0;
            rx_data    <= '0;
            sclk       <= 1'b0;
            rx_valid   <= 1'b0;
            done       <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    div_cnt <= '0;
                    sclk    <= 1'b0;
                    if (bus.start && bus.len != '0) bytes_left <= bus.len;
                end
                LOAD: begin
                    div_cnt <= '0;
                    sclk    <= 1'b0;
                    if (bus.tx_valid) begin
                        tx_shift <= bus.tx_data;
                        bit_cnt  <= '0;
                    end
                end
                SHIFT: begin
                    div_cnt <= tick ? 8'd0 : div_cnt + 8'd1;
                    if (tick) sclk <= ~sclk;
                    if (rise) rx_shift <= rx_next;
                    if (fall) begin
                        tx_shift <= tx_next;
                        bit_cnt  <= bit_cnt + 3'd1;
                    end
                    if (last) begin
                        rx_data    <= rx_shift;
                        rx_valid   <= 1'b1;
                        bytes_left <= bytes_left - LEN_W'(1);
                    end
                end
                default: begin
                    div_cnt <= tick ? 8'd0 : div_cnt + 8'd1;
                    done    <= tick;
                end
            endcase
        end
    end
endmodule
